outfifo_arbiter_rr: RTL and testbench
=====================================

# outfifo_arbiter_rr

Parametrised round-robin arbiter that merges the per-thread output FIFOs of the multicore packet engine into a single output datapath toward the MAC/output queue. It grants the output to one thread at a time, at packet granularity, and supports two modes. Strict rotation keeps packet order across threads. Work-conserving mode skips threads that have no packet ready. It adds a programmable inter-grant gap and an explicit idle state in which the output is suppressed.

## Interface
Parameters:
- NUM_THREADS, 4, number of thread output FIFOs (≥2)
- DATAPATH_WIDTH, 64, data word width per thread
- CTRL_WIDTH, 8, ctrl word width per thread
- THREAD_BITS, 2, log2(NUM_THREADS)
- STRICT_ORDER, 1, 1 = strict rotation; 0 = work-conserving skip
- GAP_CYCLES, 2, minimum cycles from a grant before the next handoff is allowed (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- thread_done  in  NUM_THREADS  pulse: thread i has a complete packet in its FIFO
- df_out_data_in  in  NUM_THREADS*DATAPATH_WIDTH  thread i data at slice [i*DATAPATH_WIDTH +: DATAPATH_WIDTH]
- df_out_ctrl_in  in  NUM_THREADS*CTRL_WIDTH  thread i ctrl at slice [i*CTRL_WIDTH +: CTRL_WIDTH]
- df_out_wr_in  in  NUM_THREADS  thread i write strobe
- df_out_wr_early_in  in  NUM_THREADS  thread i is still streaming (one cycle ahead of wr)
- out_rdy  in  1  downstream can accept
- out_data_out  out  DATAPATH_WIDTH  muxed data
- out_ctrl_out  out  CTRL_WIDTH  muxed ctrl
- out_wr_out  out  1  muxed write strobe
- fifo_start_read  out  NUM_THREADS  1-cycle pulse: thread i granted, start draining
- fifo_read_done  out  NUM_THREADS  1-cycle pulse: thread i released
- cur_thread  out  THREAD_BITS  current owner index

## Operation
- Ready latch rdy[i]:
  - Set by thread_done[i].
  - Cleared in the cycle thread i is granted. Clear wins over a coincident set; the coincident done is treated as the one being consumed.
- States:
  - IDLE: after reset, no owner. Outputs are zero; out_wr_out = 0.
  - GAP: owner granted; gap counter runs.
  - OWN: gap has expired; waiting for a handoff.
- IDLE → GAP, on a candidate in IDLE:
  - STRICT_ORDER=1: candidate is thread 0 only.
  - STRICT_ORDER=0: candidate is the lowest-index thread with rdy set.
- GAP → OWN once the counter reaches GAP_CYCLES.
- Handoff condition in OWN, all of the following:
  - df_out_wr_early_in[cur] == 0
  - out_rdy or out_rdy registered one cycle earlier is high
  - a candidate exists
- Candidate selection in OWN:
  - STRICT_ORDER=1: candidate is (cur+1) mod N, and only if its rdy is set.
  - STRICT_ORDER=0: candidate is the first thread with rdy set, scanning cur+1 … cur+N (wraps). cur itself is checked last, so a sole ready thread is re-granted.
- On handoff (OWN → GAP):
  - cur_thread ← candidate; the counter clears.
  - fifo_start_read[candidate] and fifo_read_done[old cur] pulse.
  - On self re-grant, both pulses go to the same thread in the same cycle.
- Output mux in GAP/OWN: out_data_out, out_ctrl_out and out_wr_out follow the cur_thread slices combinationally.
- Counter: 4-bit and saturating; never wraps.

## Timing
- Reset values:
  - state IDLE; cur_thread 0
  - fifo_start_read, fifo_read_done, rdy and counter all 0
  - out_wr_out 0; out_data_out and out_ctrl_out 0
- Decisions are registered:
  - A candidate evaluated in cycle t gives pulses and the new cur_thread in cycle t+1.
  - The first mux output of the new owner appears in t+1.
- thread_done in cycle t sets rdy visible in t+1. The earliest grant from IDLE is therefore pulses at t+2.
- After a grant at cycle g, the next handoff pulse comes no earlier than g+GAP_CYCLES+1.
- Reset asserted mid-packet: next cycle returns to IDLE with all latches cleared. In-flight packets are dropped from arbitration, and no read_done pulse is issued.
- Pulses are exactly one cycle wide and never overlap for different threads. The only exception is read_done[old] together with start_read[new].

## Test plan
- Strict, all ready:
  - Stimulus: thread_done=4'b1111 at cycle 1; each wr_early low.
  - Response: start_read pulses order 0,1,2,3,0; read_done 0 together with start_read 1, and so on; each grant spaced ≥ GAP_CYCLES+1.
- Strict, blocked:
  - Stimulus: owner 0; only thread 2 ready.
  - Response: no handoff, cur_thread stays 0. After thread_done[1], handoff to 1, then to 2.
- Work-conserving, skip:
  - Stimulus: STRICT_ORDER=0; owner 1; rdy = 4'b0001.
  - Response: grant thread 0 (wrap); read_done[1] in the same cycle.
- Back-pressure and streaming:
  - Stimulus: owner 2; wr_early[2]=1 for 10 cycles; out_rdy low for 2 cycles after that.
  - Response: handoff occurs only after wr_early falls and out_rdy (or its delayed copy) is high. Mux output is thread 2 data throughout.
- Coincident set/clear:
  - Stimulus: thread_done[1] in the grant cycle of 1.
  - Response: rdy[1]=0 afterwards.
- Reset mid-operation:
  - Stimulus: reset during OWN with owner 3.
  - Response: next cycle all outputs 0, state IDLE; re-arbitration starts from thread 0 (strict).

Source files
------------

// File: rtl/outfifo_arbiter_rr.sv
// Round-robin packet-granular arbiter merging per-thread output FIFOs onto one datapath.
// Supports strict rotation or work-conserving skip, with a minimum inter-grant gap.
module outfifo_arbiter_rr #(
    parameter int NUM_THREADS    = 4,
    parameter int DATAPATH_WIDTH = 64,
    parameter int CTRL_WIDTH     = 8,
    parameter int THREAD_BITS    = 2,
    parameter int STRICT_ORDER   = 1,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_THREADS-1:0]                thread_done,
    input  logic [NUM_THREADS*DATAPATH_WIDTH-1:0] df_out_data_in,
    input  logic [NUM_THREADS*CTRL_WIDTH-1:0]     df_out_ctrl_in,
    input  logic [NUM_THREADS-1:0]                df_out_wr_in,
    input  logic [NUM_THREADS-1:0]                df_out_wr_early_in,
    input  logic                                  out_rdy,
    output logic [DATAPATH_WIDTH-1:0]             out_data_out,
    output logic [CTRL_WIDTH-1:0]                 out_ctrl_out,
    output logic                                  out_wr_out,
    output logic [NUM_THREADS-1:0]                fifo_start_read,
    output logic [NUM_THREADS-1:0]                fifo_read_done,
    output logic [THREAD_BITS-1:0]                cur_thread
);

    typedef enum logic [1:0] {IDLE, GAP, OWN} state_t;

    localparam logic [3:0] GAP_LIMIT = 4'(GAP_CYCLES);

    state_t                 state_q, state_d;
    logic [THREAD_BITS-1:0] cur_thread_q, cur_thread_d;
    logic [NUM_THREADS-1:0] rdy_q, rdy_d;
    logic [NUM_THREADS-1:0] start_read_q, start_read_d;
    logic [NUM_THREADS-1:0] read_done_q, read_done_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   out_rdy_q, out_rdy_d;

    logic                   cand_valid;
    logic [THREAD_BITS-1:0] cand_idx;
    logic                   handoff;
    logic [NUM_THREADS-1:0] grant_mask;
    int                     scan_idx;

    // Candidate: in IDLE start from thread 0 (strict) or lowest ready; otherwise scan
    // after the owner, with the owner itself checked last so a sole ready thread re-wins.
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = '0;
        scan_idx   = 0;
        if (state_q == IDLE) begin
            if (STRICT_ORDER != 0) begin
                cand_valid = rdy_q[0];
            end else begin
                for (int i = NUM_THREADS - 1; i >= 0; i--) begin
                    if (rdy_q[i]) begin
                        cand_valid = 1'b1;
                        cand_idx   = THREAD_BITS'(i);
                    end
                end
            end
        end else if (STRICT_ORDER != 0) begin
            scan_idx   = (int'(cur_thread_q) + 1) % NUM_THREADS;
            cand_valid = rdy_q[THREAD_BITS'(scan_idx)];
            cand_idx   = THREAD_BITS'(scan_idx);
        end else begin
            for (int k = NUM_THREADS; k >= 1; k--) begin
                scan_idx = (int'(cur_thread_q) + k) % NUM_THREADS;
                if (rdy_q[THREAD_BITS'(scan_idx)]) begin
                    cand_valid = 1'b1;
                    cand_idx   = THREAD_BITS'(scan_idx);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_thread_d = cur_thread_q;
        start_read_d = '0;
        read_done_d  = '0;
        grant_mask   = '0;
        handoff      = 1'b0;
        out_rdy_d    = out_rdy;
        cnt_d        = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                handoff = cand_valid;
            end
            GAP: begin
                if (cnt_d >= GAP_LIMIT) state_d = OWN;
            end
            OWN: begin
                handoff = !df_out_wr_early_in[cur_thread_q] && (out_rdy || out_rdy_q) && cand_valid;
            end
            default: state_d = IDLE;
        endcase
        if (handoff) begin
            state_d                = GAP;
            cur_thread_d           = cand_idx;
            cnt_d                  = '0;
            start_read_d[cand_idx] = 1'b1;
            grant_mask[cand_idx]   = 1'b1;
            if (state_q == OWN) read_done_d[cur_thread_q] = 1'b1;
        end
        // A done arriving in the decision cycle or the pulse cycle is the packet being consumed.
        rdy_d = (rdy_q | thread_done) & ~grant_mask & ~start_read_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_thread_q <= '0;
            rdy_q        <= '0;
            start_read_q <= '0;
            read_done_q  <= '0;
            cnt_q        <= '0;
            out_rdy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_thread_q <= cur_thread_d;
            rdy_q        <= rdy_d;
            start_read_q <= start_read_d;
            read_done_q  <= read_done_d;
            cnt_q        <= cnt_d;
            out_rdy_q    <= out_rdy_d;
        end
    end

    always_comb begin
        out_data_out = '0;
        out_ctrl_out = '0;
        out_wr_out   = 1'b0;
        if (state_q != IDLE) begin
            out_data_out = df_out_data_in[int'(cur_thread_q)*DATAPATH_WIDTH +: DATAPATH_WIDTH];
            out_ctrl_out = df_out_ctrl_in[int'(cur_thread_q)*CTRL_WIDTH +: CTRL_WIDTH];
            out_wr_out   = df_out_wr_in[cur_thread_q];
        end
    end

    assign fifo_start_read = start_read_q;
    assign fifo_read_done  = read_done_q;
    assign cur_thread      = cur_thread_q;

endmodule

// File: tb/tb_outfifo_arbiter_rr.sv
// Directed bench for outfifo_arbiter_rr: one strict-order and one work-conserving
// instance share stimulus; each phase checks only the instance it targets.
module tb_outfifo_arbiter_rr;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int TB = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    thread_done;
    logic [N*DW-1:0] data_in;
    logic [N*CW-1:0] ctrl_in;
    logic [N-1:0]    wr_in;
    logic [N-1:0]    wr_early;
    logic            out_rdy;

    logic [DW-1:0] s_data, w_data;
    logic [CW-1:0] s_ctrl, w_ctrl;
    logic          s_wr, w_wr;
    logic [N-1:0]  s_start, s_done, w_start, w_done;
    logic [TB-1:0] s_cur, w_cur;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    outfifo_arbiter_rr #(.STRICT_ORDER(1)) dut_s (
        .clk(clk), .reset(reset), .thread_done(thread_done),
        .df_out_data_in(data_in), .df_out_ctrl_in(ctrl_in), .df_out_wr_in(wr_in),
        .df_out_wr_early_in(wr_early), .out_rdy(out_rdy),
        .out_data_out(s_data), .out_ctrl_out(s_ctrl), .out_wr_out(s_wr),
        .fifo_start_read(s_start), .fifo_read_done(s_done), .cur_thread(s_cur)
    );

    outfifo_arbiter_rr #(.STRICT_ORDER(0)) dut_w (
        .clk(clk), .reset(reset), .thread_done(thread_done),
        .df_out_data_in(data_in), .df_out_ctrl_in(ctrl_in), .df_out_wr_in(wr_in),
        .df_out_wr_early_in(wr_early), .out_rdy(out_rdy),
        .out_data_out(w_data), .out_ctrl_out(w_ctrl), .out_wr_out(w_wr),
        .fifo_start_read(w_start), .fifo_read_done(w_done), .cur_thread(w_cur)
    );

    function automatic logic [63:0] dataOf(input int i);
        return 64'hD0D0_0000_0000_0000 + 64'(i) * 64'h0001_0101;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkStrict(input string tag, input logic [3:0] st, input logic [3:0] dn, input int cur);
        checkOutput({tag, "_start"}, 64'(s_start), 64'(st));
        checkOutput({tag, "_done"}, 64'(s_done), 64'(dn));
        checkOutput({tag, "_cur"}, 64'(s_cur), 64'(cur));
    endtask

    task automatic checkWork(input string tag, input logic [3:0] st, input logic [3:0] dn, input int cur);
        checkOutput({tag, "_start"}, 64'(w_start), 64'(st));
        checkOutput({tag, "_done"}, 64'(w_done), 64'(dn));
        checkOutput({tag, "_cur"}, 64'(w_cur), 64'(cur));
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] td);
        reset       = rst;
        thread_done = td;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            data_in[i*DW +: DW] = dataOf(i);
            ctrl_in[i*CW +: CW] = 8'hC0 + 8'(i);
        end
        wr_in    = 4'b1010;
        wr_early = 4'b0000;
        out_rdy  = 1'b1;
        applyStimulus(1'b1, 4'b0000);
        tick();
        tick();

        // Reset state of both instances.
        checkStrict("rst_s", 4'b0000, 4'b0000, 0);
        checkWork("rst_w", 4'b0000, 4'b0000, 0);
        checkOutput("rst_data", s_data, 64'h0);
        checkOutput("rst_ctrl", 64'(s_ctrl), 64'h0);
        checkOutput("rst_wr", 64'(s_wr), 64'h0);

        // Strict rotation with all threads ready.
        applyStimulus(1'b0, 4'b1111);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("all_idle_start", 64'(s_start), 64'h0);
        tick();
        checkStrict("all_g0", 4'b0001, 4'b0000, 0);
        checkOutput("all_g0_data", s_data, dataOf(0));
        checkOutput("all_g0_wr", 64'(s_wr), 64'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            applyStimulus(1'b0, 4'b0000);
            checkOutput("all_gap1", 64'(s_start), 64'h0);
            tick();
            checkOutput("all_gap2", 64'(s_start), 64'h0);
            tick();
            checkStrict("all_rot", 4'(1 << (k % 4)), 4'(1 << (k - 1)), k % 4);
            checkOutput("all_rot_data", s_data, dataOf(k % 4));
            checkOutput("all_rot_ctrl", 64'(s_ctrl), 64'(8'hC0 + 8'(k % 4)));
            checkOutput("all_rot_wr", 64'(s_wr), 64'(k % 2));
            if (k == 1) applyStimulus(1'b0, 4'b0001);
        end

        // Strict, blocked: owner 0, only thread 2 ready.
        applyStimulus(1'b0, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            tick();
            applyStimulus(1'b0, 4'b0000);
            checkStrict("blk_hold", 4'b0000, 4'b0000, 0);
        end
        applyStimulus(1'b0, 4'b0010);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("blk_pre1", 64'(s_start), 64'h0);
        tick();
        checkStrict("blk_g1", 4'b0010, 4'b0001, 1);
        // Done for thread 1 coincident with its grant pulse is consumed.
        applyStimulus(1'b0, 4'b0010);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("coinc_rdy1", 64'(dut_s.rdy_q[1]), 64'h0);
        checkOutput("blk_gap1", 64'(s_start), 64'h0);
        tick();
        checkOutput("blk_gap2", 64'(s_start), 64'h0);
        tick();
        checkStrict("blk_g2", 4'b0100, 4'b0010, 2);

        // Back-pressure: owner 2 streams for 10 cycles, then out_rdy is low.
        wr_early = 4'b0100;
        applyStimulus(1'b0, 4'b1000);
        for (int i = 1; i <= 9; i++) begin
            tick();
            applyStimulus(1'b0, 4'b0000);
            checkStrict("bp_stream", 4'b0000, 4'b0000, 2);
            checkOutput("bp_data", s_data, dataOf(2));
        end
        out_rdy = 1'b0;
        tick();
        checkOutput("bp_norst0", 64'(s_start), 64'h0);
        wr_early = 4'b0000;
        tick();
        checkOutput("bp_norst1", 64'(s_start), 64'h0);
        tick();
        checkOutput("bp_norst2", 64'(s_start), 64'h0);
        checkOutput("bp_data_end", s_data, dataOf(2));
        out_rdy = 1'b1;
        tick();
        checkStrict("bp_g3", 4'b1000, 4'b0100, 3);
        checkOutput("bp_g3_wr", 64'(s_wr), 64'h1);

        // Reset in OWN with owner 3.
        tick();
        tick();
        applyStimulus(1'b1, 4'b0000);
        tick();
        checkStrict("mid_rst", 4'b0000, 4'b0000, 0);
        checkOutput("mid_rst_data", s_data, 64'h0);
        checkOutput("mid_rst_ctrl", 64'(s_ctrl), 64'h0);
        checkOutput("mid_rst_wr", 64'(s_wr), 64'h0);
        applyStimulus(1'b0, 4'b0110);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkStrict("re_wait0", 4'b0000, 4'b0000, 0);
        tick();
        checkStrict("re_wait1", 4'b0000, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0001);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("re_pre0", 64'(s_start), 64'h0);
        tick();
        checkStrict("re_g0", 4'b0001, 4'b0000, 0);

        // Work-conserving: owner 1 with only thread 0 ready wraps to 0; then self re-grant.
        applyStimulus(1'b1, 4'b0000);
        tick();
        tick();
        checkWork("wc_rst", 4'b0000, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0010);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("wc_pre1", 64'(w_start), 64'h0);
        tick();
        checkWork("wc_g1", 4'b0010, 4'b0000, 1);
        checkOutput("wc_g1_data", w_data, dataOf(1));
        tick();
        applyStimulus(1'b0, 4'b0001);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("wc_gap", 64'(w_start), 64'h0);
        tick();
        checkWork("wc_wrap0", 4'b0001, 4'b0010, 0);
        checkOutput("wc_wrap_ctrl", 64'(w_ctrl), 64'(8'hC0));
        tick();
        applyStimulus(1'b0, 4'b0001);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("wc_self_pre", 64'(w_start), 64'h0);
        tick();
        checkWork("wc_self", 4'b0001, 4'b0001, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
